seq_magnitude_comparator: RTL and testbench
===========================================

Name: seq_magnitude_comparator

Overview:
- Multi-cycle magnitude comparator. Compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle.
- Terminates early on the first differing digit.
- Supports unsigned and two's-complement modes, selected per operation.
- Successor to the 2-bit combinational comparator. Sits behind a start/done handshake for datapath and ALU-flag consumers.

Parameters:
- WIDTH, 8, operand width in bits.
- DIGIT, 2, bits compared per cycle. WIDTH % DIGIT must be 0.
- NSTEP, WIDTH/DIGIT, derived localparam: maximum compare steps.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request. Sampled only while busy=0.
- a  input  WIDTH  operand A. Sampled with an accepted start.
- b  input  WIDTH  operand B. Sampled with an accepted start.
- is_signed  input  1  1 = two's-complement compare. Sampled with an accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when the result updates.
- gt  output  1  A > B.
- eq  output  1  A == B.
- lt  output  1  A < B.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Reset state, applied on any edge with rst_n=0 (including mid-operation): state=IDLE, busy=0, done=0, gt=eq=lt=0.
  - In-flight compare is discarded.
  - All outputs are registered.
- FSM has two states, IDLE and CMP.
- IDLE:
  - start=1 at an edge latches a, b, is_signed into shift registers; step counter=0; goes to CMP; busy=1 from the next cycle.
  - start=0: stays in IDLE.
- Signed mode: the MSB of both latched operands is inverted at latch time (offset-binary). An unsigned digit compare then gives the signed order. Unsigned mode latches operands unchanged.
- CMP, one digit per edge:
  - Compares the top DIGIT bits of the A and B shift registers.
  - Digits differ: gt/lt set accordingly, eq=0, done=1 for one cycle, back to IDLE, busy=0.
  - Digits equal, not the last step: both registers shift left by DIGIT; counter increments.
  - Digits equal on step NSTEP-1: eq=1, gt=lt=0, done=1, back to IDLE.
- Latency: let k = 1-based index of the first differing digit, or NSTEP if the operands are equal.
  - done is high exactly k cycles after the cycle in which start was accepted.
  - Minimum latency is 1; maximum is NSTEP.
- gt/eq/lt:
  - Hold their value from one done to the next.
  - Exactly one of them is high after the first done.
  - All are zero before the first done after reset.
  - They are not cleared by a new start.
- start while busy=1 is ignored, with no queuing.
- start in the cycle where done=1: the FSM is already in IDLE, so the start is accepted. The next compare begins with no bubble, and the previous result stays visible until its own done.
- X on a/b/is_signed while start=0 has no effect.

Decomposition:
- Shared defines file comparator_defs.vh holds:
  - state encodings ST_IDLE=1'b0, ST_CMP=1'b1;
  - result one-hot constants RES_GT=3'b100, RES_EQ=3'b010, RES_LT=3'b001 (order {gt,eq,lt});
  - the elaboration-time check macro for WIDTH % DIGIT.
- Natural sub-module: cmp_digit, parametrised by DIGIT. Purely combinational; takes two DIGIT-bit inputs and produces d_gt, d_lt. The top level instantiates it once on the shift-register heads.

Test Plan:
All scenarios use WIDTH=8, DIGIT=2 (NSTEP=4).
1. Unsigned, a=0x80, b=0x7F, start for 1 cycle -> done 1 cycle later; gt=1, eq=0, lt=0; busy high exactly 1 cycle.
2. Unsigned, a=0x5A, b=0x5A -> done 4 cycles after start; eq=1, gt=lt=0.
3. a=0xFF, b=0x01:
   - is_signed=1 -> done after 1 cycle, lt=1.
   - Repeat with is_signed=0 -> gt=1.
   - Signed a=0x80 (-128), b=0x7F -> lt=1.
4. Unsigned, a=0x12, b=0x13 -> differs on the last digit; done after 4 cycles, lt=1. Then a=0x13, b=0x12 -> gt=1.
5. Handshake:
   - start pulsed again 1 cycle after acceptance (busy=1) with different operands -> ignored; result matches the first operands.
   - start held high across done -> second compare is accepted in the done cycle.
   - Old result stays until the second done.
6. Reset: rst_n=0 for 1 edge during step 2 of a compare -> next cycle busy=0, done=0, gt=eq=lt=0; no done pulse follows. A new start then completes normally.

Source files
------------

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package seq_magnitude_comparator_pkg;

  // Control FSM states; encodings are fixed so downstream debug taps can decode them.
  typedef enum logic {
    StIdle = 1'b0,
    StCmp  = 1'b1
  } state_e;

  // Result one-hot constants, ordered {gt, eq, lt}.
  localparam logic [2:0] ResGt = 3'b100;
  localparam logic [2:0] ResEq = 3'b010;
  localparam logic [2:0] ResLt = 3'b001;

  // Step counter width; a single-step compare still needs a 1-bit counter.
  function automatic int unsigned step_width(input int unsigned nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module seq_magnitude_comparator_cmp_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] digit_a,
  input  logic [DIGIT-1:0] digit_b,
  output logic             d_gt,
  output logic             d_lt
);

  // Unsigned order of the two digits; equality is implied by neither flag set.
  always_comb begin
    d_gt = 1'b0;
    d_lt = 1'b0;
    if (digit_a > digit_b) d_gt = 1'b1;
    if (digit_a < digit_b) d_lt = 1'b1;
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early termination on the
// first differing digit. Signed operands are converted to offset-binary at
// latch time so the same unsigned digit compare yields two's-complement order.
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned NSTEP = WIDTH / DIGIT;
  localparam int unsigned StepW = step_width(NSTEP);
  localparam logic [WIDTH-1:0] SignMask = WIDTH'(1) << (WIDTH - 1);
  localparam logic [StepW-1:0] LastStep = StepW'(NSTEP - 1);

  if (WIDTH % DIGIT != 0) begin : gen_width_check
    $error("seq_magnitude_comparator: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [StepW-1:0] step_q;
  logic [WIDTH-1:0] flip;
  logic             d_gt;
  logic             d_lt;

  // Digit compare on the current heads of both shift registers.
  seq_magnitude_comparator_cmp_digit #(
    .DIGIT(DIGIT)
  ) u_cmp_digit (
    .digit_a(a_q[WIDTH-1 -: DIGIT]),
    .digit_b(b_q[WIDTH-1 -: DIGIT]),
    .d_gt   (d_gt),
    .d_lt   (d_lt)
  );

  // Inverting both MSBs maps two's-complement order onto unsigned order.
  always_comb begin
    flip = '0;
    if (is_signed) flip = SignMask;
  end

  // Control FSM with registered handshake and result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      step_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a ^ flip;
            b_q     <= b ^ flip;
            step_q  <= '0;
            busy    <= 1'b1;
            state_q <= StCmp;
          end
        end
        StCmp: begin
          if (d_gt || d_lt) begin
            {gt, eq, lt} <= d_gt ? ResGt : ResLt;
            done         <= 1'b1;
            busy         <= 1'b0;
            state_q      <= StIdle;
          end else if (step_q == LastStep) begin
            {gt, eq, lt} <= ResEq;
            done         <= 1'b1;
            busy         <= 1'b0;
            state_q      <= StIdle;
          end else begin
            a_q    <= a_q << DIGIT;
            b_q    <= b_q << DIGIT;
            step_q <= step_q + StepW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed and randomised bench for seq_magnitude_comparator (WIDTH=8, DIGIT=2).
// Expected results and latencies are queued when a start is driven and
// checked when done is observed.
module tb_seq_magnitude_comparator;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  typedef struct {
    logic [2:0] res;
    int         lat;
    int         acc;
    string      tag;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_signed;
  logic         busy;
  logic         done;
  logic         gt;
  logic         eq;
  logic         lt;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];

  seq_magnitude_comparator #(
    .WIDTH(W),
    .DIGIT(D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .is_signed(is_signed),
    .busy     (busy),
    .done     (done),
    .gt       (gt),
    .eq       (eq),
    .lt       (lt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      if ($signed(x) < $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return 3'b010;
  endfunction

  // Sign conversion flips both MSBs equally, so the first differing digit is mode-independent.
  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = 0; i < N; i++) begin
      if (x[W-1-i*D -: D] != y[W-1-i*D -: D]) return i + 1;
    end
    return N;
  endfunction

  function automatic exp_t make_exp(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic s, input int acc, input string tag);
    exp_t e;
    e.res = model_res(x, y, s);
    e.lat = model_lat(x, y);
    e.acc = acc;
    e.tag = tag;
    return e;
  endfunction

  // Result checker: pops one expectation per done pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_res"}, {29'b0, gt, eq, lt}, {29'b0, e.res});
        check({e.tag, "_lat"}, cyc - e.acc, e.lat);
        check({e.tag, "_busy"}, {31'b0, busy}, 32'd0);
      end
    end
  end

  // Drive a one-cycle start from an idle DUT; call just after a rising edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input string tag);
    sb.push_back(make_exp(x, y, s, cyc + 1, tag));
    start     = 1'b1;
    a         = x;
    b         = y;
    is_signed = s;
    @(posedge clk);
    #1;
    start     = 1'b0;
    a         = 'x;
    b         = 'x;
    is_signed = 1'bx;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_res", {29'b0, gt, eq, lt}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_res", {29'b0, gt, eq, lt}, 32'd0);

    // 1: first digit differs, one-cycle busy window.
    issue(8'h80, 8'h7F, 1'b0, "t1");
    check("t1_busy_on", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("t1_busy_off", {31'b0, busy}, 32'd0);
    check("t1_done", {31'b0, done}, 32'd1);
    wait_idle(10);

    // 2: equal operands take the full NSTEP.
    issue(8'h5A, 8'h5A, 1'b0, "t2");
    wait_idle(10);

    // 3: signed versus unsigned ordering.
    issue(8'hFF, 8'h01, 1'b1, "t3_s");
    wait_idle(10);
    issue(8'hFF, 8'h01, 1'b0, "t3_u");
    wait_idle(10);
    issue(8'h80, 8'h7F, 1'b1, "t3_min");
    wait_idle(10);

    // 4: difference only in the last digit.
    issue(8'h12, 8'h13, 1'b0, "t4_lt");
    wait_idle(10);
    issue(8'h13, 8'h12, 1'b0, "t4_gt");
    wait_idle(10);

    // 5a: start while busy is ignored.
    issue(8'h40, 8'h40, 1'b0, "t5a");
    start = 1'b1;
    a     = 8'h00;
    b     = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t5a_busy", {31'b0, busy}, 32'd1);
    wait_idle(10);

    // 5b: start held across done is accepted in the done cycle.
    sb.push_back(make_exp(8'h80, 8'h7F, 1'b0, cyc + 1, "t5b_1"));
    start     = 1'b1;
    a         = 8'h80;
    b         = 8'h7F;
    is_signed = 1'b0;
    @(posedge clk);
    #1;
    a = 8'h12;
    b = 8'h13;
    sb.push_back(make_exp(8'h12, 8'h13, 1'b0, cyc + 2, "t5b_2"));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t5b_busy", {31'b0, busy}, 32'd1);
    check("t5b_hold_res", {29'b0, gt, eq, lt}, 32'd4);
    wait_idle(10);

    // 6: reset during step 2 discards the compare.
    issue(8'h5A, 8'h5A, 1'b0, "t6");
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_done", {31'b0, done}, 32'd0);
    check("t6_res", {29'b0, gt, eq, lt}, 32'd0);
    repeat (6) @(posedge clk);
    #2;
    check("t6_quiet_res", {29'b0, gt, eq, lt}, 32'd0);
    issue(8'h13, 8'h12, 1'b0, "t6_after");
    wait_idle(10);

    // Randomised operands in both modes, some differing only in one bit.
    for (int i = 0; i < 12; i++) begin
      rx = 8'($urandom);
      if (i % 2 == 1) ry = rx ^ (8'h01 << (i % 8));
      else ry = 8'($urandom);
      issue(rx, ry, 1'(i % 3 == 0), "rnd");
      wait_idle(10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
